mmu_sequencer: RTL

Sequencer for the 2x2 systolic multiply array: it buffers one 2x2 A operand and one 2x2 B operand, clears the array accumulators, and feeds the operands with the skew the array requires. After the last products drain it captures the four results into holding registers and pulses `done`. It sits between the host/load logic and the array. It owns the array's `clear`, `activation`, `a_data*` and `b_data*` inputs, and reads back `c00`..`c11`.

---
 rtl/mmu_sequencer_if.sv | 34 +++
 rtl/mmu_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mmu_sequencer_if.sv
// Bundles the host operand/control signals and the systolic array drive/readback
// signals of the 2x2 multiply sequencer.
interface mmu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic               wr_en;
  logic [2:0]         wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic               start;
  logic               relu_en;
  logic               busy;
  logic               done;
  logic               arr_clear;
  logic               arr_activation;
  logic [WIDTH-1:0]   arr_a0, arr_a1, arr_b0, arr_b1;
  logic [2*WIDTH-1:0] arr_c00, arr_c01, arr_c10, arr_c11;
  logic [2*WIDTH-1:0] res00, res01, res10, res11;

  modport slave (
    input  wr_en, wr_addr, wr_data, start, relu_en,
    input  arr_c00, arr_c01, arr_c10, arr_c11,
    output busy, done, arr_clear, arr_activation,
    output arr_a0, arr_a1, arr_b0, arr_b1,
    output res00, res01, res10, res11
  );

  modport master (
    output wr_en, wr_addr, wr_data, start, relu_en,
    output arr_c00, arr_c01, arr_c10, arr_c11,
    input  busy, done, arr_clear, arr_activation,
    input  arr_a0, arr_a1, arr_b0, arr_b1,
    input  res00, res01, res10, res11
  );
endinterface

// File: rtl/mmu_sequencer.sv
// Buffers one 2x2 A/B operand pair, clears the systolic array, feeds it with the
// diagonal skew, waits for the last products to drain and captures the results.
module mmu_sequencer #(
  parameter int WIDTH        = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  mmu_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_FEED    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;

  localparam int            DW     = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);

  logic [2:0]                 state;
  logic [1:0]                 k;
  logic [DW-1:0]              dcnt;
  logic                       relu_q;
  logic                       done_q;
  logic [7:0][WIDTH-1:0]      opnd;
  logic [3:0][2*WIDTH-1:0]    res;
  logic [WIDTH-1:0]           a0, a1, b0, b1;

  // Operand buffer is only writable in IDLE so a run sees stable operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opnd <= '0;
    end else if (state == S_IDLE && bus.wr_en) begin
      opnd[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      k      <= '0;
      dcnt   <= '0;
      relu_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_CLEAR;
            relu_q <= bus.relu_en;
          end
        end
        S_CLEAR: begin
          state <= S_FEED;
          k     <= '0;
        end
        S_FEED: begin
          if (k == 2'd2) begin
            state <= S_DRAIN;
            k     <= '0;
            dcnt  <= '0;
          end else begin
            k <= k + 2'd1;
          end
        end
        S_DRAIN: begin
          if (dcnt == D_LAST) state <= S_CAPTURE;
          else                dcnt  <= dcnt + 1'b1;
        end
        S_CAPTURE: begin
          state  <= S_IDLE;
          done_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res <= '0;
    end else if (state == S_CAPTURE) begin
      res <= {bus.arr_c11, bus.arr_c10, bus.arr_c01, bus.arr_c00};
    end
  end

  // Skewed feed: row 1 / column 1 lag row 0 / column 0 by one cycle.
  always_comb begin
    a0 = '0;
    a1 = '0;
    b0 = '0;
    b1 = '0;
    if (state == S_FEED) begin
      case (k)
        2'd0: begin
          a0 = opnd[0];
          b0 = opnd[4];
        end
        2'd1: begin
          a0 = opnd[1];
          a1 = opnd[2];
          b0 = opnd[6];
          b1 = opnd[5];
        end
        2'd2: begin
          a1 = opnd[3];
          b1 = opnd[7];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy           = (state != S_IDLE);
  assign bus.done           = done_q;
  assign bus.arr_clear      = (state == S_CLEAR);
  assign bus.arr_activation = relu_q & (state != S_IDLE);
  assign bus.arr_a0         = a0;
  assign bus.arr_a1         = a1;
  assign bus.arr_b0         = b0;
  assign bus.arr_b1         = b1;
  assign bus.res00          = res[0];
  assign bus.res01          = res[1];
  assign bus.res10          = res[2];
  assign bus.res11          = res[3];
endmodule
